// File: rtl/motor_update_scheduler_pkg.sv
// Shared motor-control definitions: scheduler state encoding and timing defaults.
package motor_update_scheduler_pkg;

  localparam int unsigned DefaultPeriodCycles  = 50000;
  localparam int unsigned DefaultTimeoutCycles = 4096;

  typedef enum logic [2:0] {
    StIdle,
    StWaitTick,
    StSelect,
    StWaitCtrl,
    StStart,
    StWaitDone,
    StNext
  } state_e;

endpackage

// File: rtl/next_motor_finder.sv
// Combinational search for the lowest set mask bit strictly above the current index.
module next_motor_finder #(
  parameter int unsigned NUM_MOTORS = 8
) (
  input  logic [NUM_MOTORS-1:0]         mask,
  input  logic [$clog2(NUM_MOTORS)-1:0] idx,
  output logic                          valid,
  output logic [$clog2(NUM_MOTORS)-1:0] next_idx
);

  localparam int unsigned IdxW = $clog2(NUM_MOTORS);

  // Scanning downward leaves the lowest qualifying index as the final assignment.
  always_comb begin
    valid    = 1'b0;
    next_idx = '0;
    for (int i = NUM_MOTORS - 1; i >= 0; i--) begin
      if (mask[i] && (IdxW'(i) > idx)) begin
        valid    = 1'b1;
        next_idx = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/motor_update_scheduler.sv
// Periodic sweep scheduler: services each enabled motor board on a shared SPI bus once per period.
module motor_update_scheduler
  import motor_update_scheduler_pkg::*;
#(
  parameter int unsigned NUM_MOTORS     = 8,
  parameter int unsigned PERIOD_CYCLES  = DefaultPeriodCycles,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          run,
  input  logic [NUM_MOTORS-1:0]         enable_mask,
  input  logic                          ctrl_busy,
  input  logic                          spi_done,
  input  logic                          err_clear,
  output logic                          spi_start,
  output logic [NUM_MOTORS-1:0]         ss_n_o,
  output logic [$clog2(NUM_MOTORS)-1:0] motor_sel,
  output logic                          cycle_done,
  output logic                          timeout_err,
  output logic                          overrun_err
);

  localparam int unsigned IdxW = $clog2(NUM_MOTORS);
  localparam int unsigned PerW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e                  state_q;
  logic [PerW-1:0]         period_cnt;
  logic [TmoW-1:0]         tmo_cnt;
  logic [NUM_MOTORS-1:0]   mask_q;
  logic [IdxW-1:0]         idx_q;
  logic                    tick;
  logic                    from0_valid;
  logic [IdxW-1:0]         from0_idx;
  logic [IdxW-1:0]         first_idx;
  logic                    nxt_valid;
  logic [IdxW-1:0]         nxt_idx;

  function automatic logic [NUM_MOTORS-1:0] ss_for(input logic [IdxW-1:0] i);
    ss_for    = '1;
    ss_for[i] = 1'b0;
  endfunction

  assign tick = run && (period_cnt == PerW'(PERIOD_CYCLES - 1));

  // Bit 0 is checked directly since the finder only looks strictly above its index.
  next_motor_finder #(.NUM_MOTORS(NUM_MOTORS)) u_first_finder (
    .mask     (enable_mask),
    .idx      ('0),
    .valid    (from0_valid),
    .next_idx (from0_idx)
  );

  assign first_idx = enable_mask[0] ? '0 : from0_idx;

  next_motor_finder #(.NUM_MOTORS(NUM_MOTORS)) u_next_finder (
    .mask     (mask_q),
    .idx      (idx_q),
    .valid    (nxt_valid),
    .next_idx (nxt_idx)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      period_cnt <= '0;
    end else if (!run || tick) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      tmo_cnt     <= '0;
      mask_q      <= '0;
      idx_q       <= '0;
      spi_start   <= 1'b0;
      ss_n_o      <= '1;
      motor_sel   <= '0;
      cycle_done  <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      spi_start  <= 1'b0;
      cycle_done <= 1'b0;
      tmo_cnt    <= tmo_cnt + 1'b1;

      if (tick && (state_q != StWaitTick)) begin
        overrun_err <= 1'b1;
      end else if (err_clear) begin
        overrun_err <= 1'b0;
      end
      // A timeout set below overrides this clear.
      if (err_clear) begin
        timeout_err <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (run) state_q <= StWaitTick;
        end
        StWaitTick: begin
          if (!run) begin
            state_q <= StIdle;
          end else if (tick && (enable_mask[0] || from0_valid)) begin
            mask_q    <= enable_mask;
            idx_q     <= first_idx;
            motor_sel <= first_idx;
            ss_n_o    <= ss_for(first_idx);
            state_q   <= StSelect;
          end
        end
        StSelect: begin
          state_q <= StWaitCtrl;
        end
        StWaitCtrl: begin
          if (!ctrl_busy) begin
            spi_start <= 1'b1;
            tmo_cnt   <= '0;
            state_q   <= StStart;
          end
        end
        StStart: begin
          state_q <= StWaitDone;
        end
        StWaitDone: begin
          if (spi_done) begin
            ss_n_o  <= '1;
            state_q <= StNext;
          end else if (tmo_cnt == TmoW'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            ss_n_o      <= '1;
            state_q     <= StNext;
          end
        end
        StNext: begin
          if (!run) begin
            state_q <= StIdle;
          end else if (nxt_valid) begin
            idx_q     <= nxt_idx;
            motor_sel <= nxt_idx;
            ss_n_o    <= ss_for(nxt_idx);
            state_q   <= StSelect;
          end else begin
            cycle_done <= 1'b1;
            state_q    <= StWaitTick;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/motor_update_scheduler.md
MOTOR_UPDATE_SCHEDULER -- requirements
Module: motor_update_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_MOTORS, default 8: number of motor boards on the shared SPI bus (2..16).
REQ-002 The block SHALL have parameter PERIOD_CYCLES, default 50000: clock cycles per update sweep (1 kHz at 50 MHz).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 4096: maximum cycles it waits for spi_done.
REQ-004 The block SHALL have port clock, input, 1 bit: single clock for all logic.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port run, input, 1 bit: level enable for periodic sweeps.
REQ-007 The block SHALL have port enable_mask, input, NUM_MOTORS bits: bit i set includes motor i in a sweep.
REQ-008 The block SHALL have port ctrl_busy, input, 1 bit: PID controller busy; a transaction does not start while it is high.
REQ-009 The block SHALL have port spi_done, input, 1 bit: single-cycle pulse when the SPI frame completes.
REQ-010 The block SHALL have port err_clear, input, 1 bit: clears the sticky error flags.
REQ-011 The block SHALL have port spi_start, output, 1 bit: single-cycle start pulse to the SPI control engine.
REQ-012 The block SHALL have port ss_n_o, output, NUM_MOTORS bits: per-motor slave selects, active low, at most one low.
REQ-013 The block SHALL have port motor_sel, output, clog2(NUM_MOTORS) bits: index of the motor being serviced.
REQ-014 The block SHALL have port cycle_done, output, 1 bit: single-cycle pulse at the end of a sweep.
REQ-015 The block SHALL have port timeout_err, output, 1 bit: sticky flag for a missing spi_done.
REQ-016 The block SHALL have port overrun_err, output, 1 bit: sticky flag for a period tick arriving while a sweep is still active.

Function
REQ-017 The period counter SHALL count 0..PERIOD_CYCLES-1 while run=1, emit an internal tick at PERIOD_CYCLES-1, then wrap to 0; it SHALL hold at 0 while run=0.
REQ-018 The FSM SHALL have states IDLE, WAIT_TICK, SELECT, WAIT_CTRL, START, WAIT_DONE and NEXT.
REQ-019 IDLE SHALL go to WAIT_TICK when run=1.
REQ-020 WAIT_TICK SHALL go to IDLE when run=0; on a tick with a nonzero mask it SHALL latch enable_mask, load the lowest set index and go to SELECT; on a tick with a zero mask it SHALL stay in WAIT_TICK with no outputs.
REQ-021 SELECT SHALL drive ss_n_o[idx] low and motor_sel to idx, then go to WAIT_CTRL.
REQ-022 WAIT_CTRL SHALL hold while ctrl_busy=1 and go to START when ctrl_busy=0.
REQ-023 START SHALL assert spi_start for exactly 1 cycle, clear the timeout counter and go to WAIT_DONE.
REQ-024 WAIT_DONE SHALL go to NEXT on spi_done; if the timeout counter reaches TIMEOUT_CYCLES-1 first, it SHALL set timeout_err and go to NEXT.
REQ-025 NEXT SHALL drive all ss_n_o high.
REQ-026 NEXT SHALL select the next latched-mask bit above idx and go to SELECT if one exists.
REQ-027 If no further latched-mask bit exists, NEXT SHALL pulse cycle_done and go to WAIT_TICK when run=1, or to IDLE when run=0.
REQ-028 Latency: with ctrl_busy=0, spi_start SHALL be high in cycle T+3, where T is the tick cycle.
REQ-029 ss_n_o[idx] SHALL be low from T+1 through the last WAIT_DONE cycle.
REQ-030 All outputs SHALL be registered.
REQ-031 Changes to enable_mask during a sweep SHALL be ignored until the next tick.
REQ-032 A tick outside WAIT_TICK SHALL set overrun_err and be discarded; a new sweep SHALL start only at a later tick.
REQ-033 When run falls mid-sweep, the current transaction SHALL complete (done or timeout), NEXT SHALL drive ss_n high, and the FSM SHALL go to IDLE without cycle_done.
REQ-034 spi_done outside WAIT_DONE SHALL be ignored.
REQ-035 err_clear SHALL clear both sticky flags; a set event in the same cycle SHALL win over the clear.
REQ-036 motor_sel SHALL hold its last value outside a sweep.

Reset
REQ-037 On reset_n=0, asynchronously: FSM to IDLE, counters 0, spi_start=0, ss_n_o all 1, motor_sel=0, cycle_done=0, timeout_err=0, overrun_err=0.
REQ-038 Reset mid-transaction SHALL release ss_n_o within the same asynchronous assertion.

Structure
REQ-039 The state encoding and the PERIOD/TIMEOUT defaults SHALL live in the shared motor-control package.
REQ-040 The next-enabled-index search SHALL be one combinational sub-module, next_motor_finder (inputs: mask and current index; outputs: valid and next index).

Verification
REQ-041 NUM_MOTORS=4, PERIOD=100, mask=4'b1011, done 10 cycles after each start -> starts for motors 0, 1, 3 in order; ss_n_o=1110, 1101, 0111 respectively; one cycle_done per sweep.
REQ-042 ctrl_busy held high 20 cycles after the tick -> spi_start delayed to the cycle after busy falls; ss_n_o stays low throughout.
REQ-043 spi_done never arrives, TIMEOUT=64 -> timeout_err=1 64 cycles after start; the sweep proceeds to the next motor; err_clear pulse -> flag returns to 0.
REQ-044 Done delayed to 150 cycles with PERIOD=100 -> overrun_err=1; no second start before the sweep completes.
REQ-045 Mask changed from 1011 to 0001 mid-sweep -> current sweep still services motor 3; the next sweep services motor 0 only.
REQ-046 reset_n pulsed low during WAIT_DONE -> ss_n_o=all 1s and spi_start=0 immediately; FSM in IDLE after release.
